// File: rtl/vblnk_update_arb_if.sv
// Handshake bundle between the blanking-window update arbiter and its requesters.
// master = arbiter side (drives grants and status), slave = requester/timing side.
interface vblnk_update_arb_if #(
  parameter int NREQ = 4
);
  logic            vblnk;
  logic [NREQ-1:0] req;
  logic [NREQ-1:0] gnt;
  logic            frame_tick;
  logic            abort;
  logic            timeout;
  logic [3:0]      served_cnt;

  modport master (
    input  vblnk, req,
    output gnt, frame_tick, abort, timeout, served_cnt
  );

  modport slave (
    output vblnk, req,
    input  gnt, frame_tick, abort, timeout, served_cnt
  );
endinterface

// File: rtl/vblnk_update_arb.sv
// Round-robin arbiter granting position updates only inside the vertical blanking window.
// Optional grant-length limit is compiled in with `define VBLNK_ARB_TIMEOUT_EN.
module vblnk_update_arb #(
  parameter int NREQ        = 4,
  parameter int TIMEOUT_CYC = 64
) (
  input logic                 clk,
  input logic                 rst,
  vblnk_update_arb_if.master  bus
);

  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    ACTIVE = 2'd0,
    ARB    = 2'd1,
    GRANT  = 2'd2
  } state_t;

  state_t            state, state_d;
  logic              vblnk_q;
  logic              rise, fall;
  logic [NREQ-1:0]   gnt, gnt_d;
  logic [IDX_W-1:0]  gidx, gidx_d;
  logic [IDX_W-1:0]  ptr, ptr_d;
  logic [3:0]        served, served_d;
  logic              frame_tick;
  logic              abort, abort_d;
  logic              timeout, timeout_d;

`ifdef VBLNK_ARB_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
  logic [CNT_W-1:0]  cnt, cnt_d;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYC > 0);
`endif

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

  // First set request searching circularly from p+1; lowest distance wins.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [NREQ-1:0] r,
                                               input logic [IDX_W-1:0] p);
    int j;
    rr_pick = p;
    for (int k = NREQ; k >= 1; k--) begin
      j = (int'(p) + k) % NREQ;
      if (r[j]) rr_pick = IDX_W'(j);
    end
  endfunction

  assign rise = bus.vblnk & ~vblnk_q;
  assign fall = ~bus.vblnk & vblnk_q;

  always_comb begin
    state_d   = state;
    gnt_d     = gnt;
    gidx_d    = gidx;
    ptr_d     = ptr;
    served_d  = rise ? 4'd0 : served;
    abort_d   = 1'b0;
    timeout_d = 1'b0;
`ifdef VBLNK_ARB_TIMEOUT_EN
    cnt_d     = cnt;
`endif
    case (state)
      ACTIVE: begin
        gnt_d = '0;
        if (rise) state_d = ARB;
      end
      ARB: begin
        if (!bus.vblnk) begin
          state_d = ACTIVE;
        end else if (|bus.req) begin
          gidx_d        = rr_pick(bus.req, ptr);
          gnt_d         = '0;
          gnt_d[gidx_d] = 1'b1;
          state_d       = GRANT;
`ifdef VBLNK_ARB_TIMEOUT_EN
          cnt_d         = '0;
`endif
        end
      end
      GRANT: begin
`ifdef VBLNK_ARB_TIMEOUT_EN
        cnt_d = cnt + CNT_W'(1);
`endif
        // Completion wins over a coincident fall; abort wins over timeout.
        if (!bus.req[gidx]) begin
          gnt_d    = '0;
          ptr_d    = gidx;
          served_d = sat_inc(served);
          state_d  = bus.vblnk ? ARB : ACTIVE;
        end else if (fall) begin
          gnt_d   = '0;
          ptr_d   = gidx;
          abort_d = 1'b1;
          state_d = ACTIVE;
        end
`ifdef VBLNK_ARB_TIMEOUT_EN
        else if (cnt == CNT_LAST) begin
          gnt_d     = '0;
          ptr_d     = gidx;
          timeout_d = 1'b1;
          state_d   = bus.vblnk ? ARB : ACTIVE;
        end
`endif
      end
      default: begin
        state_d = ACTIVE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= ACTIVE;
      gnt        <= '0;
      gidx       <= '0;
      ptr        <= IDX_W'(NREQ - 1);
      vblnk_q    <= 1'b0;
      frame_tick <= 1'b0;
      abort      <= 1'b0;
      timeout    <= 1'b0;
      served     <= 4'd0;
`ifdef VBLNK_ARB_TIMEOUT_EN
      cnt        <= '0;
`endif
    end else begin
      state      <= state_d;
      gnt        <= gnt_d;
      gidx       <= gidx_d;
      ptr        <= ptr_d;
      vblnk_q    <= bus.vblnk;
      frame_tick <= rise;
      abort      <= abort_d;
      timeout    <= timeout_d;
      served     <= served_d;
`ifdef VBLNK_ARB_TIMEOUT_EN
      cnt        <= cnt_d;
`endif
    end
  end

  assign bus.gnt        = gnt;
  assign bus.frame_tick = frame_tick;
  assign bus.abort      = abort;
  assign bus.timeout    = timeout;
  assign bus.served_cnt = served;

endmodule

// File: tb/tb_vblnk_update_arb.sv
// Directed bench for vblnk_update_arb: windowed round-robin grants, abort, completion,
// reset behaviour and (when VBLNK_ARB_TIMEOUT_EN is defined) the grant timeout.
module tb_vblnk_update_arb;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   vec_cnt = 0;
  int   err_cnt = 0;

  vblnk_update_arb_if #(.NREQ(4)) bus ();

  vblnk_update_arb #(.NREQ(4), .TIMEOUT_CYC(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    bus.vblnk = 1'b0;
    bus.req   = 4'b0000;
    rst = 1'b0;
    tick(2);
    rst = 1'b1;
    tick(1);
  endtask

  task automatic test_reset();
    bus.vblnk = 1'b0;
    bus.req   = 4'b0000;
    rst = 1'b0;
    tick(2);
    vec_cnt++; if (bus.gnt !== 4'b0000) begin err_cnt++; $display("FAIL reset_gnt: got %b want 0000", bus.gnt); end
    vec_cnt++; if (bus.frame_tick !== 1'b0) begin err_cnt++; $display("FAIL reset_frame_tick: got %b want 0", bus.frame_tick); end
    vec_cnt++; if (bus.abort !== 1'b0) begin err_cnt++; $display("FAIL reset_abort: got %b want 0", bus.abort); end
    vec_cnt++; if (bus.timeout !== 1'b0) begin err_cnt++; $display("FAIL reset_timeout: got %b want 0", bus.timeout); end
    vec_cnt++; if (bus.served_cnt !== 4'd0) begin err_cnt++; $display("FAIL reset_served: got %0d want 0", bus.served_cnt); end
    rst = 1'b1;
    tick(1);
  endtask

  task automatic test_basic();
    bus.req = 4'b0101;
    tick(3);
    bus.vblnk = 1'b1;
    tick(1);
    vec_cnt++; if (bus.frame_tick !== 1'b1) begin err_cnt++; $display("FAIL basic_frame_tick: got %b want 1", bus.frame_tick); end
    vec_cnt++; if (bus.gnt !== 4'b0000) begin err_cnt++; $display("FAIL basic_gnt_early: got %b want 0000", bus.gnt); end
    tick(1);
    vec_cnt++; if (bus.gnt !== 4'b0001) begin err_cnt++; $display("FAIL basic_gnt0: got %b want 0001", bus.gnt); end
    vec_cnt++; if (bus.frame_tick !== 1'b0) begin err_cnt++; $display("FAIL basic_frame_tick_len: got %b want 0", bus.frame_tick); end
    tick(7);
    vec_cnt++; if (bus.gnt !== 4'b0001) begin err_cnt++; $display("FAIL basic_gnt0_held: got %b want 0001", bus.gnt); end
    bus.req = 4'b0100;
    tick(1);
    vec_cnt++; if (bus.gnt !== 4'b0000) begin err_cnt++; $display("FAIL basic_gnt_gap: got %b want 0000", bus.gnt); end
    vec_cnt++; if (bus.served_cnt !== 4'd1) begin err_cnt++; $display("FAIL basic_served1: got %0d want 1", bus.served_cnt); end
    tick(1);
    vec_cnt++; if (bus.gnt !== 4'b0100) begin err_cnt++; $display("FAIL basic_gnt2: got %b want 0100", bus.gnt); end
    bus.req = 4'b0000;
    tick(1);
    vec_cnt++; if (bus.served_cnt !== 4'd2) begin err_cnt++; $display("FAIL basic_served2: got %0d want 2", bus.served_cnt); end
    bus.vblnk = 1'b0;
    tick(2);
  endtask

  task automatic test_round_robin();
    logic [3:0] exp;
    do_reset();
    bus.req = 4'b1111;
    for (int w = 0; w < 3; w++) begin
      bus.vblnk = 1'b1;
      tick(1);
      vec_cnt++; if (bus.served_cnt !== 4'd0) begin err_cnt++; $display("FAIL rr_served_clear w%0d: got %0d want 0", w, bus.served_cnt); end
      tick(1);
      for (int i = 0; i < 4; i++) begin
        exp = 4'b0001 << i;
        vec_cnt++; if (bus.gnt !== exp) begin err_cnt++; $display("FAIL rr_order w%0d g%0d: got %b want %b", w, i, bus.gnt, exp); end
        tick(4);
        bus.req[i] = 1'b0;
        tick(1);
        vec_cnt++; if (bus.gnt !== 4'b0000) begin err_cnt++; $display("FAIL rr_release w%0d g%0d: got %b want 0000", w, i, bus.gnt); end
        bus.req = 4'b1111;
        if (i == 3) bus.vblnk = 1'b0;
        tick(1);
      end
      vec_cnt++; if (bus.served_cnt !== 4'd4) begin err_cnt++; $display("FAIL rr_served_end w%0d: got %0d want 4", w, bus.served_cnt); end
      vec_cnt++; if (bus.gnt !== 4'b0000) begin err_cnt++; $display("FAIL rr_idle w%0d: got %b want 0000", w, bus.gnt); end
      tick(2);
    end
  endtask

  task automatic test_abort();
    bus.req   = 4'b0110;
    bus.vblnk = 1'b1;
    tick(2);
    vec_cnt++; if (bus.gnt !== 4'b0010) begin err_cnt++; $display("FAIL abort_pre_gnt: got %b want 0010", bus.gnt); end
    tick(2);
    bus.vblnk = 1'b0;
    tick(1);
    vec_cnt++; if (bus.gnt !== 4'b0000) begin err_cnt++; $display("FAIL abort_gnt: got %b want 0000", bus.gnt); end
    vec_cnt++; if (bus.abort !== 1'b1) begin err_cnt++; $display("FAIL abort_pulse: got %b want 1", bus.abort); end
    vec_cnt++; if (bus.served_cnt !== 4'd0) begin err_cnt++; $display("FAIL abort_served: got %0d want 0", bus.served_cnt); end
    tick(1);
    vec_cnt++; if (bus.abort !== 1'b0) begin err_cnt++; $display("FAIL abort_len: got %b want 0", bus.abort); end
    tick(2);
    vec_cnt++; if (bus.gnt !== 4'b0000) begin err_cnt++; $display("FAIL abort_idle: got %b want 0000", bus.gnt); end
    bus.vblnk = 1'b1;
    tick(2);
    vec_cnt++; if (bus.gnt !== 4'b0100) begin err_cnt++; $display("FAIL abort_next_window: got %b want 0100", bus.gnt); end
  endtask

  task automatic test_same_cycle();
    bus.req = 4'b1000;
    tick(1);
    vec_cnt++; if (bus.served_cnt !== 4'd1) begin err_cnt++; $display("FAIL same_served1: got %0d want 1", bus.served_cnt); end
    tick(1);
    vec_cnt++; if (bus.gnt !== 4'b1000) begin err_cnt++; $display("FAIL same_gnt3: got %b want 1000", bus.gnt); end
    tick(2);
    bus.req   = 4'b0000;
    bus.vblnk = 1'b0;
    tick(1);
    vec_cnt++; if (bus.gnt !== 4'b0000) begin err_cnt++; $display("FAIL same_gnt: got %b want 0000", bus.gnt); end
    vec_cnt++; if (bus.abort !== 1'b0) begin err_cnt++; $display("FAIL same_abort: got %b want 0", bus.abort); end
    vec_cnt++; if (bus.served_cnt !== 4'd2) begin err_cnt++; $display("FAIL same_served2: got %0d want 2", bus.served_cnt); end
    tick(2);
  endtask

  task automatic test_timeout();
    do_reset();
    bus.req   = 4'b0011;
    bus.vblnk = 1'b1;
    tick(2);
    vec_cnt++; if (bus.gnt !== 4'b0001) begin err_cnt++; $display("FAIL to_gnt_first: got %b want 0001", bus.gnt); end
`ifdef VBLNK_ARB_TIMEOUT_EN
    for (int c = 1; c < 8; c++) begin
      tick(1);
      vec_cnt++; if (bus.gnt !== 4'b0001 || bus.timeout !== 1'b0) begin err_cnt++; $display("FAIL to_hold c%0d: got gnt=%b to=%b want gnt=0001 to=0", c, bus.gnt, bus.timeout); end
    end
    tick(1);
    vec_cnt++; if (bus.gnt !== 4'b0000) begin err_cnt++; $display("FAIL to_revoke: got %b want 0000", bus.gnt); end
    vec_cnt++; if (bus.timeout !== 1'b1) begin err_cnt++; $display("FAIL to_pulse: got %b want 1", bus.timeout); end
    vec_cnt++; if (bus.served_cnt !== 4'd0) begin err_cnt++; $display("FAIL to_served: got %0d want 0", bus.served_cnt); end
    tick(1);
    vec_cnt++; if (bus.gnt !== 4'b0010) begin err_cnt++; $display("FAIL to_next: got %b want 0010", bus.gnt); end
    vec_cnt++; if (bus.timeout !== 1'b0) begin err_cnt++; $display("FAIL to_len: got %b want 0", bus.timeout); end
`else
    tick(20);
    vec_cnt++; if (bus.gnt !== 4'b0001) begin err_cnt++; $display("FAIL nto_hold: got %b want 0001", bus.gnt); end
    vec_cnt++; if (bus.timeout !== 1'b0) begin err_cnt++; $display("FAIL nto_timeout: got %b want 0", bus.timeout); end
`endif
    bus.req   = 4'b0000;
    bus.vblnk = 1'b0;
    tick(3);
  endtask

  task automatic test_reset_mid_grant();
    do_reset();
    bus.req   = 4'b0110;
    bus.vblnk = 1'b1;
    tick(2);
    vec_cnt++; if (bus.gnt !== 4'b0010) begin err_cnt++; $display("FAIL rmg_gnt1: got %b want 0010", bus.gnt); end
    bus.req = 4'b0100;
    tick(2);
    vec_cnt++; if (bus.gnt !== 4'b0100 || bus.served_cnt !== 4'd1) begin err_cnt++; $display("FAIL rmg_gnt2: got gnt=%b served=%0d want gnt=0100 served=1", bus.gnt, bus.served_cnt); end
    rst = 1'b0;
    tick(1);
    vec_cnt++; if (bus.gnt !== 4'b0000) begin err_cnt++; $display("FAIL rmg_gnt_clear: got %b want 0000", bus.gnt); end
    vec_cnt++; if (bus.abort !== 1'b0) begin err_cnt++; $display("FAIL rmg_abort: got %b want 0", bus.abort); end
    vec_cnt++; if (bus.served_cnt !== 4'd0) begin err_cnt++; $display("FAIL rmg_served: got %0d want 0", bus.served_cnt); end
    bus.req = 4'b0101;
    rst = 1'b1;
    tick(1);
    vec_cnt++; if (bus.frame_tick !== 1'b1) begin err_cnt++; $display("FAIL rmg_rise: got %b want 1", bus.frame_tick); end
    tick(1);
    vec_cnt++; if (bus.gnt !== 4'b0001) begin err_cnt++; $display("FAIL rmg_first_gnt: got %b want 0001", bus.gnt); end
    bus.req   = 4'b0000;
    bus.vblnk = 1'b0;
    tick(2);
  endtask

  initial begin
    bus.vblnk = 1'b0;
    bus.req   = 4'b0000;
    test_reset();
    test_basic();
    test_round_robin();
    test_abort();
    test_same_cycle();
    test_timeout();
    test_reset_mid_grant();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
